// File: rtl/addsub_share_ctrl.sv
// rtl/addsub_share_ctrl.sv - two-requester arbiter and sequencer for a shared 16-bit saturating add/sub unit
module addsub_share_ctrl #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_A,
  input  logic [15:0]      req0_B,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_A,
  input  logic [15:0]      req1_B,
  input  logic             req1_sub,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [15:0]      rsp_sum,
  output logic             rsp_ovfl,
  output logic [15:0]      au_A,
  output logic [15:0]      au_B,
  output logic             au_sub,
  input  logic [15:0]      au_Sum,
  input  logic             au_Ovfl,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ovfl_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  state_t state_nxt;
  logic   owner;
  logic   last_grant;
  logic   winner;
  logic   accept;

  // Tie-break: fixed priority favours requester 0, round-robin favours whoever was not granted last.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = FIXED_PRIO ? 1'b0 : ~last_grant;
    end else begin
      winner = ~req0_valid;
    end
  end

  // Next-state and handshake outputs; the response is offered only to the owner of the op.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = ~winner;
          req1_ready = winner;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        if (owner ? rsp1_ready : rsp0_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand registers double as the shared-unit drive, so they stay put through EXEC and RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      au_A       <= 16'h0000;
      au_B       <= 16'h0000;
      au_sub     <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      au_A       <= winner ? req1_A : req0_A;
      au_B       <= winner ? req1_B : req0_B;
      au_sub     <= winner ? req1_sub : req0_sub;
      owner      <= winner;
      last_grant <= winner;
    end
  end

  // Capture the unit's combinational result at the end of EXEC; held until the next capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_sum  <= 16'h0000;
      rsp_ovfl <= 1'b0;
    end else if (state == EXEC) begin
      rsp_sum  <= au_Sum;
      rsp_ovfl <= au_Ovfl;
    end
  end

  // Saturating overflow counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      ovfl_cnt <= '0;
    end else if ((state == EXEC) && au_Ovfl && (ovfl_cnt != {CNT_W{1'b1}})) begin
      ovfl_cnt <= ovfl_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// tb/tb_addsub_share_ctrl.sv - self-checking bench for addsub_share_ctrl (round-robin/CNT_W=8 and fixed-prio/CNT_W=2)
module tb_addsub_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, v0, v1, s0, s1, rr0, rr1, clr;
  logic [1:0][15:0] a0, b0, a1, b1;
  logic [1:0]       rdy0, rdy1, val0, val1, ovfl, au_sub, au_ovfl;
  logic [1:0][15:0] sum, au_a, au_b, au_sum;
  logic [7:0]       cnt0;
  logic [1:0]       cnt1;

  int checks = 0;
  int failures = 0;

  // Behavioural model of the external saturating add/sub unit.
  function automatic logic [16:0] sat(input logic [15:0] a, input logic [15:0] b, input logic s);
    int x, y, r;
    logic [16:0] res;
    x = $signed(a);
    y = $signed(b);
    r = s ? x - y : x + y;
    if (r > 32767) res = {1'b1, 16'h7FFF};
    else if (r < -32768) res = {1'b1, 16'h8000};
    else res = {1'b0, r[15:0]};
    return res;
  endfunction

  assign {au_ovfl[0], au_sum[0]} = sat(au_a[0], au_b[0], au_sub[0]);
  assign {au_ovfl[1], au_sum[1]} = sat(au_a[1], au_b[1], au_sub[1]);

  addsub_share_ctrl u0 (
    .clk(clk), .rst(rst[0]),
    .req0_valid(v0[0]), .req0_ready(rdy0[0]), .req0_A(a0[0]), .req0_B(b0[0]), .req0_sub(s0[0]),
    .req1_valid(v1[0]), .req1_ready(rdy1[0]), .req1_A(a1[0]), .req1_B(b1[0]), .req1_sub(s1[0]),
    .rsp0_valid(val0[0]), .rsp0_ready(rr0[0]), .rsp1_valid(val1[0]), .rsp1_ready(rr1[0]),
    .rsp_sum(sum[0]), .rsp_ovfl(ovfl[0]),
    .au_A(au_a[0]), .au_B(au_b[0]), .au_sub(au_sub[0]), .au_Sum(au_sum[0]), .au_Ovfl(au_ovfl[0]),
    .clr_cnt(clr[0]), .ovfl_cnt(cnt0)
  );

  addsub_share_ctrl #(.FIXED_PRIO(1'b1), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst[1]),
    .req0_valid(v0[1]), .req0_ready(rdy0[1]), .req0_A(a0[1]), .req0_B(b0[1]), .req0_sub(s0[1]),
    .req1_valid(v1[1]), .req1_ready(rdy1[1]), .req1_A(a1[1]), .req1_B(b1[1]), .req1_sub(s1[1]),
    .rsp0_valid(val0[1]), .rsp0_ready(rr0[1]), .rsp1_valid(val1[1]), .rsp1_ready(rr1[1]),
    .rsp_sum(sum[1]), .rsp_ovfl(ovfl[1]),
    .au_A(au_a[1]), .au_B(au_b[1]), .au_sub(au_sub[1]), .au_Sum(au_sum[1]), .au_Ovfl(au_ovfl[1]),
    .clr_cnt(clr[1]), .ovfl_cnt(cnt1)
  );

  // Transaction-level reference: one outstanding op per instance, age = cycles since accept.
  bit          pend [2];
  bit          own  [2];
  bit          last [2];
  bit          ms   [2];
  bit          movf [2];
  int          age  [2];
  int          mcnt [2];
  logic [15:0] ma   [2];
  logic [15:0] mb   [2];
  logic [15:0] msum [2];
  int          cmax [2] = '{255, 3};
  bit          fixed[2] = '{1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    pend[i] = 1'b0; own[i] = 1'b0; last[i] = 1'b1; ms[i] = 1'b0; movf[i] = 1'b0;
    age[i] = 0; mcnt[i] = 0; ma[i] = 16'h0; mb[i] = 16'h0; msum[i] = 16'h0;
  endtask

  task automatic clear_inputs();
    rst = 2'b00; v0 = 2'b00; v1 = 2'b00; s0 = 2'b00; s1 = 2'b00;
    rr0 = 2'b00; rr1 = 2'b00; clr = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
  endtask

  // One clock cycle: inputs already applied at the falling edge; check, advance model, move to next falling edge.
  task automatic tick();
    bit w, e0, e1, ev0, ev1, cap;
    logic [16:0] r;
    #1;
    for (int i = 0; i < 2; i++) begin
      w   = (v0[i] && v1[i]) ? (fixed[i] ? 1'b0 : !last[i]) : !v0[i];
      e0  = !pend[i] && v0[i] && !w;
      e1  = !pend[i] && v1[i] && w;
      ev0 = pend[i] && (age[i] >= 2) && !own[i];
      ev1 = pend[i] && (age[i] >= 2) && own[i];
      check($sformatf("u%0d req0_ready", i), 32'(rdy0[i]), 32'(e0));
      check($sformatf("u%0d req1_ready", i), 32'(rdy1[i]), 32'(e1));
      check($sformatf("u%0d rsp0_valid", i), 32'(val0[i]), 32'(ev0));
      check($sformatf("u%0d rsp1_valid", i), 32'(val1[i]), 32'(ev1));
      check($sformatf("u%0d rsp_sum", i), 32'(sum[i]), 32'(msum[i]));
      check($sformatf("u%0d rsp_ovfl", i), 32'(ovfl[i]), 32'(movf[i]));
      check($sformatf("u%0d au_A", i), 32'(au_a[i]), 32'(ma[i]));
      check($sformatf("u%0d au_B", i), 32'(au_b[i]), 32'(mb[i]));
      check($sformatf("u%0d au_sub", i), 32'(au_sub[i]), 32'(ms[i]));
      check($sformatf("u%0d ovfl_cnt", i), (i == 0) ? 32'(cnt0) : 32'(cnt1), 32'(mcnt[i]));
      if (rst[i]) begin
        model_reset(i);
      end else begin
        cap = pend[i] && (age[i] == 1);
        r = 17'h0;
        if (cap) begin
          r = sat(ma[i], mb[i], ms[i]);
          movf[i] = r[16];
          msum[i] = r[15:0];
        end
        if (clr[i]) mcnt[i] = 0;
        else if (cap && r[16] && (mcnt[i] < cmax[i])) mcnt[i]++;
        if (e0 || e1) begin
          pend[i] = 1'b1; age[i] = 1; own[i] = e1; last[i] = e1;
          ma[i] = e1 ? a1[i] : a0[i];
          mb[i] = e1 ? b1[i] : b0[i];
          ms[i] = e1 ? s1[i] : s0[i];
        end else if (pend[i]) begin
          if (age[i] == 1) age[i] = 2;
          else if (own[i] ? rr1[i] : rr0[i]) pend[i] = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 2'b11;
    tick();
    rst = 2'b00;
  endtask

  task automatic drain();
    v0 = 2'b00; v1 = 2'b00; rr0 = 2'b11; rr1 = 2'b11;
    repeat (3) tick();
    rr0 = 2'b00; rr1 = 2'b00;
  endtask

  initial begin
    clear_inputs();
    rst = 2'b11;
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    @(negedge clk);
    tick();
    rst = 2'b00;

    // 0x0005 - 0x0003 from requester 0 alone
    v0[0] = 1'b1; a0[0] = 16'h0005; b0[0] = 16'h0003; s0[0] = 1'b1; rr0[0] = 1'b1;
    tick();
    v0[0] = 1'b0;
    tick();
    tick();
    check("t1 rsp_sum", 32'(sum[0]), 32'h0002);

    // positive and negative saturation from requester 1
    v1[0] = 1'b1; a1[0] = 16'h7000; b1[0] = 16'h2000; s1[0] = 1'b0; rr1[0] = 1'b1;
    tick();
    v1[0] = 1'b0;
    tick();
    tick();
    check("t2 sum pos", 32'(sum[0]), 32'h7FFF);
    v1[0] = 1'b1; a1[0] = 16'h8000; b1[0] = 16'h0001; s1[0] = 1'b1;
    tick();
    v1[0] = 1'b0;
    tick();
    tick();
    check("t2 sum neg", 32'(sum[0]), 32'h8000);
    check("t2 ovfl_cnt", 32'(cnt0), 32'd2);

    // both requesters held from reset: round-robin on u0, fixed priority on u1
    do_reset();
    v0 = 2'b11; v1 = 2'b11; rr0 = 2'b11; rr1 = 2'b11;
    a0 = {16'h0011, 16'h0010}; b0 = {16'h0001, 16'h0001};
    a1 = {16'h0120, 16'h0100}; b1 = {16'h0002, 16'h0002};
    repeat (12) tick();
    drain();

    // stalled response while the other requester waits
    v0[0] = 1'b1; a0[0] = 16'h1234; b0[0] = 16'h0034; s0[0] = 1'b1;
    tick();
    v0[0] = 1'b0; v1[0] = 1'b1; a1[0] = 16'h0100; b1[0] = 16'h0001; s1[0] = 1'b0;
    repeat (6) tick();
    check("t4 stalled sum", 32'(sum[0]), 32'h1200);
    rr0[0] = 1'b1;
    tick();
    rr0[0] = 1'b0;
    tick();
    v1[0] = 1'b0; rr1[0] = 1'b1;
    tick();
    tick();
    check("t4 req1 sum", 32'(sum[0]), 32'h0101);
    drain();

    // reset during EXEC drops the op
    v0[0] = 1'b1; a0[0] = 16'h0042; b0[0] = 16'h0001; rr0[0] = 1'b1;
    tick();
    v0[0] = 1'b0; rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    repeat (4) tick();
    rr0[0] = 1'b0;

    // CNT_W=2 saturation and clear coincident with an overflow capture
    do_reset();
    v0[1] = 1'b1; a0[1] = 16'h7000; b0[1] = 16'h2000; rr0[1] = 1'b1;
    repeat (12) tick();
    v0[1] = 1'b0;
    tick();
    check("t6 cnt sat", 32'(cnt1), 32'd3);
    v0[1] = 1'b1;
    tick();
    v0[1] = 1'b0; clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    tick();
    check("t6 clr wins", 32'(cnt1), 32'd0);
    drain();

    // randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        v0[i]  = ($urandom_range(0, 2) != 0);
        v1[i]  = ($urandom_range(0, 2) != 0);
        a0[i]  = 16'($urandom);
        b0[i]  = 16'($urandom);
        a1[i]  = 16'($urandom);
        b1[i]  = 16'($urandom);
        s0[i]  = 1'($urandom);
        s1[i]  = 1'($urandom);
        rr0[i] = 1'($urandom);
        rr1[i] = 1'($urandom);
        clr[i] = ($urandom_range(0, 31) == 0);
        rst[i] = ($urandom_range(0, 255) == 0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
